// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the switch/button debounce front end.
// Timing defaults are derived from the board clock rate.
package switch_debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_e;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEB_CYC_DEF  = CLK_HZ / 50;   // 20 ms
    localparam int HOLD_CYC_DEF = CLK_HZ;        // 1 s
    localparam int CNT_W_DEF    = 27;

    // HIGH and WAIT_LOW both present a clean level of 1.
    function automatic logic state_is_high(deb_state_e s);
        return (s == HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stable-time FSM and long-hold timer.
// All outputs are registered; raw input only feeds the first sync flop.
module debounce_ch
    import switch_debounce_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       sync_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             hold_q, hold_d;
    logic             s;

    assign s = sync_q[1];

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        hold_d     = 1'b0;
        // '>=' keeps DEB_CYC=1 resolving on the first WAIT cycle
        case (state_q)
            LOW: begin
                if (s) begin
                    state_d   = WAIT_HIGH;
                    deb_cnt_d = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = LOW;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d    = HIGH;
                    rise_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d   = WAIT_LOW;
                    deb_cnt_d = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HIGH;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d = LOW;
                    fall_d  = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            default: state_d = LOW;
        endcase
        // Saturating one past the fire point marks "already fired" for this high period.
        if (state_is_high(state_q) && state_is_high(state_d) && (hold_cnt_q < HOLD_SAT)) begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
            hold_d     = (hold_cnt_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= LOW;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], p_i};
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hold_q     <= hold_d;
        end
    end

    assign level_o = state_is_high(state_q);
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign hold_o  = hold_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounce front end for the board switches/buttons: clean levels plus
// rise, fall and long-hold event pulses, one independent channel per input.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] P,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] hold_pulse
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        debounce_ch #(
            .DEB_CYC (DEB_CYC),
            .HOLD_CYC(HOLD_CYC),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .p_i    (P[c]),
            .level_o(level[c]),
            .rise_o (rise_pulse[c]),
            .fall_o (fall_pulse[c]),
            .hold_o (hold_pulse[c])
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: step table, hand-written corner sequences and
// random stimulus against a run-length reference model.
module tb_switch_debounce;

    localparam int N    = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 32;
    localparam int CW   = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] P     = '0;
    logic [N-1:0] level, rise_pulse, fall_pulse, hold_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_debounce #(
        .N_CH(N), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .P(P), .level(level),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .hold_pulse(hold_pulse)
    );

    // Reference: level flips once the (2-cycle delayed) input has disagreed with
    // it for DEB consecutive samples; hold fires when the high time reaches HOLD.
    logic [N-1:0] m_h0, m_h1, m_lvl, m_rise, m_fall, m_hold;
    int           m_run [N];
    int           m_ht  [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h0 <= '0; m_h1 <= '0; m_lvl <= '0;
            m_rise <= '0; m_fall <= '0; m_hold <= '0;
            for (int c = 0; c < N; c++) begin
                m_run[c] <= 0;
                m_ht[c]  <= 0;
            end
        end else begin
            m_h0 <= P;
            m_h1 <= m_h0;
            for (int c = 0; c < N; c++) begin
                automatic int   r    = (m_h1[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                automatic logic flip = (r == DEB);
                m_rise[c] <= flip && !m_lvl[c];
                m_fall[c] <= flip && m_lvl[c];
                m_lvl[c]  <= m_lvl[c] ^ flip;
                m_run[c]  <= flip ? 0 : r;
                if (flip && !m_lvl[c]) begin
                    m_ht[c]   <= 0;
                    m_hold[c] <= 1'b0;
                end else if (m_lvl[c] && !flip) begin
                    m_ht[c]   <= m_ht[c] + 1;
                    m_hold[c] <= (m_ht[c] + 1 == HOLD);
                end else begin
                    m_hold[c] <= 1'b0;
                end
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({level, rise_pulse, fall_pulse, hold_pulse} !== {m_lvl, m_rise, m_fall, m_hold}) begin
                failures++;
                $display("FAIL model t=%0t lvl/rise/fall/hold actual=%b/%b/%b/%b required=%b/%b/%b/%b",
                         $time, level, rise_pulse, fall_pulse, hold_pulse,
                         m_lvl, m_rise, m_fall, m_hold);
            end
        end
    end

    // Pulse accumulators, sampled just after each active edge.
    logic [N-1:0] acc_r = '0, acc_f = '0, acc_h = '0;
    int           hold3_cnt = 0;
    always @(posedge clk) begin
        #1;
        acc_r     |= rise_pulse;
        acc_f     |= fall_pulse;
        acc_h     |= hold_pulse;
        hold3_cnt += int'(hold_pulse[3]);
    end

    task automatic clr_acc();
        acc_r = '0; acc_f = '0; acc_h = '0; hold3_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] p;
        int           cyc;
        logic [N-1:0] lvl, r, f, h;
    } row_t;

    row_t tbl [9];

    initial begin
        tbl[0] = '{4'b0011, 10, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0010,  7, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0011, 20, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0011, 10, 4'b0011, 4'b0000, 4'b0000, 4'b0011};
        tbl[4] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
        tbl[5] = '{4'b1100,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[6] = '{4'b1100,  1, 4'b1100, 4'b1100, 4'b0000, 4'b0000};
        tbl[7] = '{4'b0100,  3, 4'b1100, 4'b0000, 4'b0000, 4'b0000};
        tbl[8] = '{4'b1000, 10, 4'b1000, 4'b0000, 4'b0100, 4'b0000};

        #1 rst_n = 1'b0;
        step(3);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_level", 32'(level), 0);
        chk("rst_pulses", 32'({rise_pulse, fall_pulse, hold_pulse}), 0);

        // Idle inputs: nothing happens.
        @(negedge clk); clr_acc();
        step(40);
        chk("idle_level", 32'(level), 0);
        chk("idle_pulses", 32'({acc_r, acc_f, acc_h}), 0);

        for (int i = 0; i < 9; i++) begin
            P = tbl[i].p;
            clr_acc();
            step(tbl[i].cyc);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_rise", i),  32'(acc_r),  32'(tbl[i].r));
            chk($sformatf("tbl%0d_fall", i),  32'(acc_f),  32'(tbl[i].f));
            chk($sformatf("tbl%0d_hold", i),  32'(acc_h),  32'(tbl[i].h));
        end

        P = '0;
        do_reset();
        @(negedge clk);

        // Single step on channel 0: level and rise exactly 10 cycles later.
        P = 4'b0001; clr_acc();
        step(9);
        chk("step_early_level", 32'(level), 0);
        step(1);
        chk("step_level", 32'(level), 32'h1);
        chk("step_rise", 32'(rise_pulse), 32'h1);
        step(1);
        chk("step_rise_1cyc", 32'(rise_pulse), 0);

        // Bounce on channel 1 never qualifies.
        clr_acc();
        P = 4'b0011; step(5);
        P = 4'b0001; step(3);
        P = 4'b0011; step(4);
        P = 4'b0001; step(20);
        chk("bounce_level", 32'(level), 32'h1);
        chk("bounce_rise", 32'(acc_r), 0);

        // Long hold on channel 3.
        clr_acc();
        P = 4'b1001;
        step(10);
        chk("hold_rise", 32'(rise_pulse), 32'h8);
        step(31);
        chk("hold_early", hold3_cnt, 0);
        step(1);
        chk("hold_pulse", 32'(hold_pulse), 32'h8);
        step(8);
        P = 4'b0001;
        step(9);
        chk("rel_fall_early", 32'(fall_pulse), 0);
        step(1);
        chk("rel_fall", 32'(fall_pulse), 32'h8);
        chk("rel_level", 32'(level), 32'h1);
        chk("hold_once", hold3_cnt, 1);

        // Simultaneous rises on channels 0 and 3.
        P = 4'b0000; step(12);
        P = 4'b1001; clr_acc();
        step(10);
        chk("simul_rise", 32'(rise_pulse), 32'h9);
        chk("simul_level", 32'(level), 32'h9);

        // Reset in the middle of a pending rise on channel 2.
        P = 4'b0000; step(12);
        clr_acc();
        P = 4'b0100;
        step(6);
        #2 rst_n = 1'b0;
        #1 chk("midrst_level", 32'(level), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        step(9);
        chk("postrst_early", 32'(level), 0);
        step(1);
        chk("postrst_rise", 32'(rise_pulse), 32'h4);
        chk("postrst_level", 32'(level), 32'h4);
        chk("postrst_nofall", 32'(acc_f), 0);

        // Random: bouncy phase, then slow phase reaching hold, one reset in between.
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, (i < 800) ? 6 : 40) == 0) P[c] = ~P[c];
            if (i == 700) begin
                #2 rst_n = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
